vv_alu_multiop: RTL and testbench
=================================

Name: vv_alu_multiop

Overview:
- Next-generation vector-vector ALU stage of the tracing pipeline.
- Each valid input vector is combined lane-wise with a vector read from an internal per-block vector register file (VRF), selected by a per-chain firmware entry.
- The result can optionally be written back to the VRF, with read-after-write forwarding so back-to-back accumulations are exact.
- Adds over the previous generation: signed min/max ops, correct condition gating, runtime firmware loading over the config bus, and an asynchronous reset.

Parameters:
- N, 8: number of lanes per vector.
- DATA_WIDTH, 32: bits per lane, two's complement.
- MAX_CHAINS, 4: number of firmware entries; must be ≥2 and a power of 2.
- VRF_DEPTH, 8: VRF entries; must be a power of 2; address width AW=$clog2(VRF_DEPTH).
- PERSONAL_CONFIG_ID, 0: configId value that selects this block.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- tracing, input, 1: enables outputs and VRF writes.
- valid_in, input, 1: vector_in is valid this cycle.
- eof_in, input, 1: last vector of frame.
- bof_in, input, 1: first vector of frame.
- chainId_in, input, $clog2(MAX_CHAINS): firmware select.
- configId, input, 8: config bus target id.
- configData, input, 8: config bus payload byte.
- vector_in, input, N x DATA_WIDTH: input vector.
- vector_out, output, N x DATA_WIDTH: result vector.
- chainId_out, output, $clog2(MAX_CHAINS): delayed chainId.
- valid_out, output, 1: vector_out valid.
- eof_out, output, 1: delayed eof.
- bof_out, output, 1: delayed bof.

Behaviour:
- Reset, asynchronous, active-low:
  - All outputs go to 0.
  - Every firmware field goes to 0, which is pass-through with no cache.
  - Config pointer goes to 0.
  - VRF contents go to 0.
  - All pipeline registers go to 0.
  - Reset asserted mid-stream discards in-flight vectors; no partial write occurs.
- Firmware, per chain, 8-bit fields: op, addr_rd, cond, cache, cache_addr.
  - addr_rd and cache_addr use their low AW bits.
  - cache is nonzero = write-back enabled.
- Config load:
  - Each cycle with configId==PERSONAL_CONFIG_ID, configData is written to the field at config pointer ptr, and ptr increments.
  - Field order is chain-major: chain0 {op, addr_rd, cond, cache, cache_addr}, chain1 {...}, and so on.
  - After byte 5*MAX_CHAINS-1, ptr wraps to 0.
  - Config is accepted regardless of tracing.
  - A new field affects only vectors entering S0 on a later cycle.
- Pipeline, latency exactly 2 cycles from valid_in to valid_out:
  - S0 edge:
    - Register vector_in, valid, eof, bof and chainId.
    - Register the firmware fields of chainId_in.
    - Register operand <= VRF[addr_rd].
    - If a VRF write to the same address happens on the same edge, the operand takes the write data (forwarding).
  - S1, combinational:
    - op 0 = pass vector_in.
    - op 1 = in+operand.
    - op 2 = low DATA_WIDTH bits of in*operand.
    - op 3 = in-operand.
    - op 4 = signed max.
    - op 5 = signed min.
    - ops 6..255 = pass.
    - Add/sub wrap modulo 2^DATA_WIDTH.
  - Condition cond_ok:
    - 0 = always.
    - 1 = eof.
    - 2 = !eof.
    - 3 = bof.
    - 4 = !bof.
    - Any other value = never.
  - S1 edge:
    - vector_out <= cond_ok ? result : vector_in (S1 copy).
    - valid_out <= S1 valid & tracing.
    - eof/bof/chainId out are delayed copies.
    - vector_out, eof_out, bof_out and chainId_out update every cycle; only valid_out is qualified.
- VRF write:
  - Occurs at the S1 edge when S1 valid & tracing & cache & cond_ok.
  - Writes VRF[cache_addr] <= result.
- Throughput: one vector per cycle, no backpressure, no stalls.
- Back-to-back accumulation into the same address is exact: the forwarding guarantees this.

Optional Feature:
- VVALU_SATURATE_EN defined:
  - ops 1 and 3 saturate to the signed range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - op 2 saturates when the full-width signed product is out of range.
- VVALU_SATURATE_EN undefined: add, sub and mul wrap; no extra logic.

Test Plan (N=4, DATA_WIDTH=32, MAX_CHAINS=4, VRF_DEPTH=8):
- Reset, then vector_in={1,2,3,4}, valid_in=1, chain 0, tracing=1 -> 2 cycles later valid_out=1 and vector_out={1,2,3,4}; VRF is unchanged.
- Config load: stream 20 bytes to PERSONAL_CONFIG_ID, with chain1={1,3,0,1,3} -> chain1 becomes add+cache at addr 3.
  - Five consecutive vectors {1,1,1,1} on chain1 -> outputs {1..},{2..},{3..},{4..},{5..}, proving forwarding on every cycle.
- chain2 = op 1, cond 1, cache to addr 5:
  - Send {10,...} with eof=0 -> output passes {10,...}, no write.
  - Then eof=1 -> output {10,...} plus VRF[5]; VRF[5] is written.
- Ops 4 and 5:
  - VRF entry {-5,7,0,-1}, input {3,-9,0,-2}.
  - max -> {3,7,0,-1}.
  - min -> {-5,-9,0,-2}.
- tracing=0 with valid_in=1 -> valid_out stays 0 and cache writes are suppressed; reasserting tracing resumes with latency 2.
- Add 0x7FFFFFFF+1:
  - Without VVALU_SATURATE_EN -> 0x80000000.
  - With VVALU_SATURATE_EN -> 0x7FFFFFFF.
- Reset asserted between the S0 and S1 edges -> no VRF write; outputs are 0.

Source files
------------

// File: rtl/vv_alu_multiop.sv
// Vector-vector ALU stage: each lane combines the input vector with a VRF operand picked by per-chain firmware,
// with optional write-back and read-after-write forwarding. Define VVALU_SATURATE_EN for saturating add/sub/mul.
module vv_alu_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [7:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res
);
  localparam int DW = DATA_WIDTH;

  logic signed [DW-1:0] sa, sb;
  logic [DW-1:0] add_r, sub_r, mul_r;

  assign sa = $signed(a);
  assign sb = $signed(b);

`ifdef VVALU_SATURATE_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  logic [DW:0]     sum, dif;
  logic [2*DW-1:0] prod;

  // One guard bit catches add/sub overflow; the full product is checked for a clean sign extension.
  always_comb begin
    sum   = {a[DW-1], a} + {b[DW-1], b};
    dif   = {a[DW-1], a} - {b[DW-1], b};
    prod  = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    add_r = (sum[DW] != sum[DW-1]) ? (sum[DW] ? SMIN : SMAX) : sum[DW-1:0];
    sub_r = (dif[DW] != dif[DW-1]) ? (dif[DW] ? SMIN : SMAX) : dif[DW-1:0];
    mul_r = (prod[2*DW-1:DW-1] != {(DW+1){prod[2*DW-1]}}) ? (prod[2*DW-1] ? SMIN : SMAX)
                                                         : prod[DW-1:0];
  end
`else
  assign add_r = a + b;
  assign sub_r = a - b;
  assign mul_r = a * b;
`endif

  always_comb begin
    res = a;
    case (op)
      8'd1:    res = add_r;
      8'd2:    res = mul_r;
      8'd3:    res = sub_r;
      8'd4:    res = (sa > sb) ? a : b;
      8'd5:    res = (sa < sb) ? a : b;
      default: res = a;
    endcase
  end
endmodule

module vv_alu_multiop #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int VRF_DEPTH          = 8,
  parameter int PERSONAL_CONFIG_ID = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                tracing,
  input  logic                                valid_in,
  input  logic                                eof_in,
  input  logic                                bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0]       chainId_in,
  input  logic [7:0]                          configId,
  input  logic [7:0]                          configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0]       chainId_out,
  output logic                                valid_out,
  output logic                                eof_out,
  output logic                                bof_out
);
  localparam int CW     = $clog2(MAX_CHAINS);
  localparam int AW     = $clog2(VRF_DEPTH);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [7:0]    op;
    logic [AW-1:0] addr_rd;
    logic [7:0]    cond;
    logic [7:0]    cache;
    logic [AW-1:0] cache_addr;
  } fw_t;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  fw_t           fw [MAX_CHAINS];
  logic [2:0]    ptr_fld;
  logic [CW-1:0] ptr_chn;
  logic          cfg_hit;

  vec_t          vrf [VRF_DEPTH];

  logic [STAGES:0] vld_pipe;
  vec_t          in_q, opnd_q, result;
  logic          eof_q, bof_q;
  logic [CW-1:0] chn_q;
  logic [7:0]    op_q, cond_q;
  logic          cache_q;
  logic [AW-1:0] caddr_q;

  fw_t           fw_rd;
  logic          cond_ok, wr_en, fwd;

  assign cfg_hit = (configId == 8'(PERSONAL_CONFIG_ID));
  assign fw_rd   = fw[chainId_in];

  // Config bytes land chain-major, five fields per chain; the chain counter wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < MAX_CHAINS; c++) fw[c] <= '0;
      ptr_fld <= '0;
      ptr_chn <= '0;
    end else if (cfg_hit) begin
      case (ptr_fld)
        3'd0:    fw[ptr_chn].op         <= configData;
        3'd1:    fw[ptr_chn].addr_rd    <= configData[AW-1:0];
        3'd2:    fw[ptr_chn].cond       <= configData;
        3'd3:    fw[ptr_chn].cache      <= configData;
        3'd4:    fw[ptr_chn].cache_addr <= configData[AW-1:0];
        default: ;
      endcase
      if (ptr_fld == 3'd4) begin
        ptr_fld <= '0;
        ptr_chn <= ptr_chn + CW'(1);
      end else begin
        ptr_fld <= ptr_fld + 3'd1;
      end
    end
  end

  always_comb begin
    cond_ok = 1'b0;
    case (cond_q)
      8'd0:    cond_ok = 1'b1;
      8'd1:    cond_ok = eof_q;
      8'd2:    cond_ok = !eof_q;
      8'd3:    cond_ok = bof_q;
      8'd4:    cond_ok = !bof_q;
      default: cond_ok = 1'b0;
    endcase
  end

  assign wr_en = vld_pipe[0] & tracing & cache_q & cond_ok;
  // The write retiring on this edge is what the entering vector must see.
  assign fwd   = wr_en && (caddr_q == fw_rd.addr_rd);

  for (genvar l = 0; l < N; l++) begin : g_lane
    vv_alu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .op  (op_q),
      .a   (in_q[l]),
      .b   (opnd_q[l]),
      .res (result[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < VRF_DEPTH; a++) vrf[a] <= '0;
    end else if (wr_en) begin
      vrf[caddr_q] <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      in_q        <= '0;
      opnd_q      <= '0;
      eof_q       <= 1'b0;
      bof_q       <= 1'b0;
      chn_q       <= '0;
      op_q        <= '0;
      cond_q      <= '0;
      cache_q     <= 1'b0;
      caddr_q     <= '0;
      vector_out  <= '0;
      eof_out     <= 1'b0;
      bof_out     <= 1'b0;
      chainId_out <= '0;
    end else begin
      vld_pipe[0] <= valid_in;
      in_q        <= vector_in;
      eof_q       <= eof_in;
      bof_q       <= bof_in;
      chn_q       <= chainId_in;
      op_q        <= fw_rd.op;
      cond_q      <= fw_rd.cond;
      cache_q     <= |fw_rd.cache;
      caddr_q     <= fw_rd.cache_addr;
      opnd_q      <= fwd ? result : vrf[fw_rd.addr_rd];

      vld_pipe[1] <= vld_pipe[0] & tracing;
      vector_out  <= cond_ok ? result : in_q;
      eof_out     <= eof_q;
      bof_out     <= bof_q;
      chainId_out <= chn_q;
    end
  end

  assign valid_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_vv_alu_multiop.sv
// Directed bench for vv_alu_multiop: a transaction-level model (sequential VRF semantics) checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_vv_alu_multiop;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MC = 4;
  localparam int VD = 8;
  localparam int CW = 2;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tracing = 1'b0;
  logic          valid_in = 1'b0;
  logic          eof_in = 1'b0;
  logic          bof_in = 1'b0;
  logic [CW-1:0] chainId_in = '0;
  logic [7:0]    configId = 8'hFF;
  logic [7:0]    configData = '0;
  vec_t          vector_in = '0;
  vec_t          vector_out;
  logic [CW-1:0] chainId_out;
  logic          valid_out, eof_out, bof_out;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vv_alu_multiop #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .VRF_DEPTH(VD), .PERSONAL_CONFIG_ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in), .bof_in(bof_in),
    .chainId_in(chainId_in), .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out), .chainId_out(chainId_out), .valid_out(valid_out), .eof_out(eof_out),
    .bof_out(bof_out)
  );

  task automatic chkv(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t vec4(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  // Model: vectors retire in order against a plain VRF array, so the operand is always
  // the VRF state after every earlier vector's write-back.
  logic [4:0][7:0] fw_m [MC];
  vec_t            vrf_m [VD];
  int              cptr;
  logic            p_v, p_e, p_b;
  logic [CW-1:0]   p_ch;
  vec_t            p_in;
  logic [4:0][7:0] p_f;
  vec_t            m_res;
  bit              m_ok;
  vec_t            exp_vec = '0;
  logic            exp_v = 1'b0, exp_e = 1'b0, exp_b = 1'b0;
  logic [CW-1:0]   exp_ch = '0;

  function automatic bit cond_m(input logic [7:0] c, input logic e, input logic b);
    case (c)
      8'd0: return 1'b1;
      8'd1: return e;
      8'd2: return !e;
      8'd3: return b;
      8'd4: return !b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_m(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    longint hi, lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      8'd1: r = sa + sb;
      8'd2: r = sa * sb;
      8'd3: r = sa - sb;
      8'd4: return (sa > sb) ? a : b;
      8'd5: return (sa < sb) ? a : b;
      default: return a;
    endcase
`ifdef VVALU_SATURATE_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    if (hi == lo) r = 0;
`endif
    return r[31:0];
  endfunction

  initial begin
    cptr = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < MC; c++) fw_m[c] = '0;
        for (int a = 0; a < VD; a++) vrf_m[a] = '0;
        cptr = 0;
        p_v = 0; p_e = 0; p_b = 0; p_ch = '0; p_in = '0; p_f = '0;
        exp_vec = '0; exp_v = 0; exp_e = 0; exp_b = 0; exp_ch = '0;
      end else begin
        m_ok = cond_m(p_f[2], p_e, p_b);
        for (int l = 0; l < N; l++) m_res[l] = lane_m(p_f[0], p_in[l], vrf_m[p_f[1][2:0]][l]);
        exp_vec = m_ok ? m_res : p_in;
        exp_v   = p_v && tracing;
        exp_e   = p_e;
        exp_b   = p_b;
        exp_ch  = p_ch;
        if (p_v && tracing && m_ok && p_f[3] != 8'd0) vrf_m[p_f[4][2:0]] = m_res;
        p_v = valid_in; p_e = eof_in; p_b = bof_in; p_ch = chainId_in; p_in = vector_in;
        p_f = fw_m[chainId_in];
        if (configId == 8'd0) begin
          fw_m[cptr / 5][cptr % 5] = configData;
          cptr = (cptr + 1) % (5 * MC);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chkv("model_vector_out", vector_out, exp_vec);
        chk1("model_valid_out", 8'(valid_out), 8'(exp_v));
        chk1("model_eof_out", 8'(eof_out), 8'(exp_e));
        chk1("model_bof_out", 8'(bof_out), 8'(exp_b));
        chk1("model_chainId_out", 8'(chainId_out), 8'(exp_ch));
      end
    end
  end

  logic [7:0] tbl [5*MC];

  task automatic set_chain(input int c, input logic [7:0] op, input logic [7:0] ard, input logic [7:0] cond,
                           input logic [7:0] cache, input logic [7:0] cad);
    tbl[c*5+0] = op; tbl[c*5+1] = ard; tbl[c*5+2] = cond; tbl[c*5+3] = cache; tbl[c*5+4] = cad;
  endtask

  task automatic load_fw();
    for (int i = 0; i < 5*MC; i++) begin
      @(negedge clk);
      configId = 8'd0;
      configData = tbl[i];
    end
    @(negedge clk);
    configId = 8'hFF;
  endtask

  task automatic drv(input logic [CW-1:0] ch, input vec_t v, input logic e, input logic b);
    valid_in = 1'b1; chainId_in = ch; vector_in = v; eof_in = e; bof_in = b;
  endtask

  task automatic idle();
    valid_in = 1'b0; eof_in = 1'b0; bof_in = 1'b0;
  endtask

  initial begin
    vec_t ov;
    repeat (3) @(negedge clk);
    chkv("rst_vector_out", vector_out, '0);
    chk1("rst_valid_out", 8'(valid_out), 8'd0);
    chk1("rst_eof_bof_chain", {3'b0, eof_out, bof_out, 1'b0, chainId_out}, 8'd0);
    #2 rst_n = 1'b1;
    tracing = 1'b1;

    // Reset firmware is pass-through.
    @(negedge clk); drv(2'd0, vec4(1, 2, 3, 4), 1'b0, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    chkv("pass_vec", vector_out, vec4(1, 2, 3, 4));
    chk1("pass_valid", 8'(valid_out), 8'd1);
    chk1("pass_bof", 8'(bof_out), 8'd1);

    set_chain(0, 0, 0, 0, 0, 0);
    set_chain(1, 1, 3, 0, 1, 3);
    set_chain(2, 1, 5, 1, 1, 5);
    set_chain(3, 0, 0, 0, 1, 6);
    load_fw();

    // Back-to-back accumulation into VRF[3].
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chkv("accum_vec", vector_out, vec4(i-1, i-1, i-1, i-1));
        chk1("accum_valid", 8'(valid_out), 8'd1);
      end
      if (i < 5) drv(2'd1, vec4(1, 1, 1, 1), 1'b0, 1'b0);
      else idle();
    end

    // Conditional write-back on eof.
    @(negedge clk); drv(2'd2, vec4(10, 10, 10, 10), 1'b0, 1'b0);
    @(negedge clk); drv(2'd2, vec4(10, 10, 10, 10), 1'b1, 1'b0);
    @(negedge clk); chkv("cond_false_pass", vector_out, vec4(10, 10, 10, 10));
    drv(2'd2, vec4(10, 10, 10, 10), 1'b1, 1'b0);
    @(negedge clk); chkv("cond_true_add", vector_out, vec4(10, 10, 10, 10));
    chk1("cond_eof_out", 8'(eof_out), 8'd1);
    idle();
    @(negedge clk); chkv("cond_written", vector_out, vec4(20, 20, 20, 20));

    // Seed VRF[6], then max/min against it.
    @(negedge clk); drv(2'd3, vec4(-5, 7, 0, -1), 1'b0, 1'b0);
    @(negedge clk); idle();
    @(negedge clk); chkv("seed_vrf6", vector_out, vec4(-5, 7, 0, -1));
    set_chain(2, 5, 6, 0, 0, 0);
    set_chain(3, 4, 6, 0, 0, 0);
    load_fw();
    @(negedge clk); drv(2'd3, vec4(3, -9, 0, -2), 1'b0, 1'b0);
    @(negedge clk); drv(2'd2, vec4(3, -9, 0, -2), 1'b0, 1'b0);
    @(negedge clk); chkv("max", vector_out, vec4(3, 7, 0, -1));
    chk1("max_chain", 8'(chainId_out), 8'd3);
    idle();
    @(negedge clk); chkv("min", vector_out, vec4(-5, -9, 0, -2));

    // tracing low: no valid_out, no write-back into VRF[3] (holds 5).
    @(negedge clk); tracing = 1'b0; drv(2'd1, vec4(1, 1, 1, 1), 1'b0, 1'b0);
    @(negedge clk); drv(2'd1, vec4(1, 1, 1, 1), 1'b0, 1'b0);
    @(negedge clk); chk1("notrace_valid0", 8'(valid_out), 8'd0); idle();
    @(negedge clk); chk1("notrace_valid1", 8'(valid_out), 8'd0);
    chkv("notrace_nowrite", vector_out, vec4(6, 6, 6, 6));
    tracing = 1'b1; drv(2'd1, vec4(1, 1, 1, 1), 1'b0, 1'b0);
    @(negedge clk); idle();
    @(negedge clk); chkv("retrace_vec", vector_out, vec4(6, 6, 6, 6));
    chk1("retrace_valid", 8'(valid_out), 8'd1);

    // Overflow, mul and sub against VRF[7]={1..} and VRF[6].
    set_chain(0, 1, 7, 0, 0, 0);
    set_chain(1, 2, 6, 0, 0, 0);
    set_chain(2, 3, 6, 0, 0, 0);
    set_chain(3, 0, 0, 0, 1, 7);
    load_fw();
    @(negedge clk); drv(2'd3, vec4(1, 1, 1, 1), 1'b0, 1'b0);
    @(negedge clk); idle();
    @(negedge clk); drv(2'd0, vec4(32'h7FFFFFFF, 0, 32'hFFFFFFFF, 32'h80000000), 1'b0, 1'b0);
    @(negedge clk); drv(2'd1, vec4(3, -9, 0, -2), 1'b0, 1'b0);
    @(negedge clk);
`ifdef VVALU_SATURATE_EN
    ov = vec4(32'h7FFFFFFF, 1, 0, 32'h80000001);
`else
    ov = vec4(32'h80000000, 1, 0, 32'h80000001);
`endif
    chkv("add_overflow", vector_out, ov);
    drv(2'd2, vec4(3, -9, 0, -2), 1'b0, 1'b0);
    @(negedge clk); chkv("mul", vector_out, vec4(-15, -63, 0, 2)); idle();
    @(negedge clk); chkv("sub", vector_out, vec4(8, -16, 0, -1));

    // Reset between the S0 and S1 edges of an in-flight write-back.
    @(negedge clk); drv(2'd3, vec4(9, 9, 9, 9), 1'b0, 1'b0);
    @(negedge clk); idle();
    #2 rst_n = 1'b0;
    #1 chkv("midrst_vec", vector_out, '0);
    chk1("midrst_valid", 8'(valid_out), 8'd0);
    @(negedge clk); chkv("midrst_hold_vec", vector_out, '0);
    chk1("midrst_hold_valid", 8'(valid_out), 8'd0);
    #2 rst_n = 1'b1;
    @(negedge clk); drv(2'd3, vec4(1, 2, 3, 4), 1'b0, 1'b0);
    @(negedge clk); idle();
    @(negedge clk); chkv("post_rst_pass", vector_out, vec4(1, 2, 3, 4));
    chk1("post_rst_valid", 8'(valid_out), 8'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
